// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and constants for countdown_timer.
`default_nettype none

package countdown_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int ZERO          = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: loadable, pausable down-counter with busy/done handshake.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN.
`default_nettype none

module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_value
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(ZERO);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;
  logic             busy_n;

  always_comb begin
    state_n = state;
    count_n = out_value;
    done_n  = 1'b0;

    // A start is serviced identically from every state; a zero load is a
    // zero-length interval that completes immediately without going busy.
    if (start) begin
      if (load_value != CNT_ZERO) begin
        count_n = load_value;
        state_n = RUN;
      end else begin
        count_n = CNT_ZERO;
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_n = HOLD;
          end else if (out_value == CNT_ONE) begin
            done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (load_value != CNT_ZERO) begin
              count_n = load_value;
              state_n = RUN;
            end else begin
              count_n = CNT_ZERO;
              state_n = IDLE;
            end
`else
            count_n = CNT_ZERO;
            state_n = IDLE;
`endif
          end else begin
            count_n = out_value - CNT_ONE;
          end
        end
        HOLD: begin
          if (!pause) begin
            state_n = RUN;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_value <= CNT_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      out_value <= count_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed, table-driven checks for countdown_timer (one-shot build).
`default_nettype none

module tb_countdown_timer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         busy;
  logic         done;
  logic [W-1:0] out_value;

  int passed;
  int total;

  typedef struct {
    logic         start;
    logic         pause;
    logic [W-1:0] load;
    logic [W-1:0] exp_out;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .busy       (busy),
    .done       (done),
    .out_value  (out_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic s, input logic p, input int l,
                     input int o, input logic b, input logic d);
    vec_t v;
    v.start    = s;
    v.pause    = p;
    v.load     = W'(l);
    v.exp_out  = W'(o);
    v.exp_busy = b;
    v.exp_done = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] o,
                       input logic b, input logic d);
    total++;
    if (out_value === o && busy === b && done === d) begin
      passed++;
    end else begin
      $display("FAIL %s: got out=%0d busy=%0b done=%0b, expected out=%0d busy=%0b done=%0b",
               name, out_value, busy, done, o, b, d);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic [W-1:0] l);
    start      = s;
    pause      = p;
    load_value = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    passed     = 0;
    total      = 0;
    reset      = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    load_value = '0;

    #2;
    check("reset_state", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 4'd7);
    check("release_idle", 4'd0, 1'b0, 1'b0);

    // load 4: 4,3,2,1,0 with a single done coincident with 0
    add(1, 0, 4, 4, 1, 0);
    add(0, 0, 9, 3, 1, 0);
    add(0, 0, 9, 2, 1, 0);
    add(0, 0, 9, 1, 1, 0);
    add(0, 0, 9, 0, 0, 1);
    add(0, 0, 9, 0, 0, 0);
    // load 6, pause three cycles at 3, then one resume cycle
    add(1, 0, 6, 6, 1, 0);
    add(0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 3, 1, 0);
    add(0, 1, 0, 3, 1, 0);
    add(0, 1, 0, 3, 1, 0);
    add(0, 1, 0, 3, 1, 0);
    add(0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1);
    // zero-length interval, then pause in IDLE ignored
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0);
    // restart at 5 with start+pause together: start wins
    add(1, 0, 9, 9, 1, 0);
    add(0, 0, 9, 8, 1, 0);
    add(0, 0, 9, 7, 1, 0);
    add(0, 0, 9, 6, 1, 0);
    add(0, 0, 9, 5, 1, 0);
    add(1, 1, 2, 2, 1, 0);
    add(0, 0, 9, 1, 1, 0);
    add(0, 0, 9, 0, 0, 1);
    // start while done is high is serviced normally
    add(1, 0, 2, 2, 1, 0);
    add(0, 0, 2, 1, 1, 0);
    add(0, 0, 2, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1);
    // restart from RUN with zero load, and restart from HOLD
    add(1, 0, 3, 3, 1, 0);
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 3, 3, 1, 0);
    add(0, 1, 0, 3, 1, 0);
    add(1, 1, 15, 15, 1, 0);
    add(0, 0, 0, 14, 1, 0);
    add(1, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].pause, vecs[i].load);
      check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // asynchronous reset mid-count takes effect without a clock edge
    step(1'b1, 1'b0, 4'd8);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check("pre_reset_run", 4'd5, 1'b1, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check("post_reset_idle", 4'd0, 1'b0, 1'b0);

    // full-scale interval: done exactly 15 edges after acceptance
    step(1'b1, 1'b0, 4'd15);
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    total++;
    if (cycles == 15 && done === 1'b1 && out_value === 4'd0) begin
      passed++;
    end else begin
      $display("FAIL max_interval: got %0d cycles done=%0b, expected 15 cycles done=1",
               cycles, done);
    end
    step(1'b0, 1'b0, 4'd0);
    check("max_interval_idle", 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
